// File: rtl/compound_accumulator_pkg.sv
// ----------------------------------------------------------------------------
// compound_accumulator_types
// Shared types and constants for the compound accumulator stage.
//   CompoundType : input record  {x: signed 32-bit payload, y: frame-end flag}
//   SummaryType  : output record {sum: signed 32-bit, count: 16-bit, ovf}
//   AccState     : accumulator FSM state
//   SUM_MAX/MIN  : signed 32-bit clamp limits
// ----------------------------------------------------------------------------
package compound_accumulator_types;

    typedef struct packed {
        logic signed [31:0] x;
        logic               y;
    } CompoundType;

    typedef struct packed {
        logic signed [31:0] sum;
        logic [15:0]        count;
        logic               ovf;
    } SummaryType;

    typedef enum logic [0:0] {
        READ_IN   = 1'b0,
        WRITE_OUT = 1'b1
    } AccState;

    localparam logic [31:0] SUM_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SUM_MIN = 32'h8000_0000;

endpackage

// File: rtl/compound_accumulator_sat_add32.sv
// ----------------------------------------------------------------------------
// sat_add32
// Combinational signed 32-bit adder with optional saturation.
//   i_a, i_b : signed operands
//   o_sum    : a + b, clamped to SUM_MAX/SUM_MIN on overflow when SAT_EN=1,
//              otherwise the two's-complement wrapped result
//   o_ovf    : 1 when the true sum does not fit in 32 signed bits
// ----------------------------------------------------------------------------
module sat_add32
    import compound_accumulator_types::*;
#(
    parameter bit SAT_EN = 1'b1
)
(
    input  logic signed [31:0] i_a,
    input  logic signed [31:0] i_b,
    output logic signed [31:0] o_sum,
    output logic               o_ovf
);

    logic [31:0] w_raw;

    assign w_raw = i_a + i_b;

    // Overflow only when both operands share a sign and the result flips it.
    assign o_ovf = (i_a[31] == i_b[31]) && (w_raw[31] != i_a[31]);

    always_comb begin
        o_sum = w_raw;
        if (SAT_EN && o_ovf) begin
            // Operand sign tells which rail was crossed.
            o_sum = i_a[31] ? SUM_MIN : SUM_MAX;
        end
    end

endmodule

// File: rtl/compound_accumulator.sv
// ----------------------------------------------------------------------------
// compound_accumulator
// Accumulates the signed payload of a CompoundType record stream into one
// running sum per frame and emits a SummaryType record per frame. A frame
// closes on the record's frame-end flag or when the record count reaches
// MAX_COUNT.
//
// Handshake (both ports): a transfer happens on a posedge where notify and
// sync are both 1. notify is the block's ready/valid; sync is the partner's.
// sync while notify is 0 has no effect.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   b_in          : input record
//   b_in_sync     : producer offers b_in
//   b_in_notify   : block ready to take b_in (READ_IN)
//   s_out         : summary record, held until accepted and afterwards
//   s_out_sync    : consumer accepts s_out
//   s_out_notify  : s_out valid (WRITE_OUT)
//   o_dbg_state   : current FSM state for observation
// ----------------------------------------------------------------------------
module compound_accumulator
    import compound_accumulator_types::*;
#(
    parameter int MAX_COUNT = 1024,
    parameter bit SAT_EN    = 1'b1
)
(
    input  logic        clk,
    input  logic        rst,
    input  CompoundType b_in,
    input  logic        b_in_sync,
    output logic        b_in_notify,
    output SummaryType  s_out,
    input  logic        s_out_sync,
    output logic        s_out_notify,
    output AccState     o_dbg_state
);

    localparam logic [15:0] LP_MAX_COUNT = 16'(MAX_COUNT);

    AccState            r_state;
    logic signed [31:0] r_acc;
    logic [15:0]        r_cnt;
    logic               r_ovf;
    SummaryType         r_s_out;

    logic signed [31:0] w_sum;
    logic               w_add_ovf;
    logic [15:0]        w_cnt_n;
    logic               w_ovf_n;
    logic               w_close;
    logic               w_in_xfer;
    logic               w_out_xfer;

    sat_add32 #(
        .SAT_EN (SAT_EN)
    ) u_sat_add (
        .i_a   (r_acc),
        .i_b   (b_in.x),
        .o_sum (w_sum),
        .o_ovf (w_add_ovf)
    );

    // Both notifies come straight from the state, so reset forces them
    // immediately and they can never be asserted together.
    assign b_in_notify  = (r_state == READ_IN);
    assign s_out_notify = (r_state == WRITE_OUT);
    assign s_out        = r_s_out;
    assign o_dbg_state  = r_state;

    assign w_in_xfer  = b_in_notify  & b_in_sync;
    assign w_out_xfer = s_out_notify & s_out_sync;

    // r_cnt stays below MAX_COUNT inside a frame, so the increment never wraps.
    assign w_cnt_n = r_cnt + 16'd1;
    assign w_ovf_n = r_ovf | w_add_ovf;
    assign w_close = b_in.y | (w_cnt_n == LP_MAX_COUNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= READ_IN;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_s_out <= '0;
        end else begin
            case (r_state)
                READ_IN: begin
                    if (w_in_xfer) begin
                        if (w_close) begin
                            // Capture the frame including this record and
                            // start the next frame from a clean slate.
                            r_s_out <= '{sum: w_sum, count: w_cnt_n, ovf: w_ovf_n};
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_ovf   <= 1'b0;
                            r_state <= WRITE_OUT;
                        end else begin
                            r_acc <= w_sum;
                            r_cnt <= w_cnt_n;
                            r_ovf <= w_ovf_n;
                        end
                    end
                end
                WRITE_OUT: begin
                    // s_out is deliberately left holding the last summary.
                    if (w_out_xfer) begin
                        r_state <= READ_IN;
                    end
                end
                default: r_state <= READ_IN;
            endcase
        end
    end

endmodule
